// File: rtl/uart_rx_core.sv
// uart_rx_core: USART1 serial receiver (8N1) with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1) and the io_parity_odd input.
module uart_rx_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              io_clk,
    input  logic              io_rst,
    input  logic              io_rx,
    input  logic [DIV_W-1:0]  io_clkdiv,
`ifdef UART_RX_PARITY_EN
    input  logic              io_parity_odd,
`endif
    output logic [DATA_W-1:0] io_rx_data,
    output logic              io_rx_valid,
    input  logic              io_rx_ready,
    output logic              io_frame_err,
    output logic              io_parity_err,
    output logic              io_overrun,
    output logic              io_busy
);

    localparam int unsigned      BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]        fill_q;
    logic              armed_q, armed_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              perr_q, perr_d;
    logic              par_exp;
`endif

    logic [DIV_W-1:0]  div_eff;
    logic              start_edge;
    logic              tick;
    logic              done;
    logic              stop_ok;

    assign div_eff    = (io_clkdiv < MIN_DIV) ? MIN_DIV : io_clkdiv;
    assign tick       = (cnt_q == '0);
    assign start_edge = armed_q & rx_prev_q & ~rx_sync_q;
    // Arm only once the synchronizer carries a real high from the pin, so a line held low
    // across reset release is never mistaken for a start bit.
    assign armed_d    = armed_q | (fill_q[1] & rx_sync_q);
`ifdef UART_RX_PARITY_EN
    assign par_exp    = (^shift_q) ^ io_parity_odd;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        done    = 1'b0;
        stop_ok = 1'b1;

        if (state_q != StIdle && !tick) begin
            cnt_d = cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    cnt_d   = div_eff >> 1;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rx_sync_q) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = div_eff - 1'b1;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
                    cnt_d   = div_eff - 1'b1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    par_bad_d = (rx_sync_q != par_exp);
                    cnt_d     = div_eff - 1'b1;
                    state_d   = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                // Leave mid-stop-bit so the next start edge can be caught back-to-back.
                if (tick) begin
                    done    = 1'b1;
                    stop_ok = rx_sync_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif

        if (valid_q && io_rx_ready) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end

        if (done) begin
            if (!valid_q || io_rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = ~stop_ok;
`ifdef UART_RX_PARITY_EN
                perr_d  = par_bad_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= '0;
            armed_q   <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= io_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign io_rx_data   = data_q;
    assign io_rx_valid  = valid_q;
    assign io_frame_err = valid_q & ferr_q;
    assign io_overrun   = overrun_q;
    assign io_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign io_parity_err = valid_q & perr_q;
`else
    assign io_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine for the USART1 peripheral: samples the asynchronous `RX` line (GPIOB[1]), frames 8N1/8E1/8O1 characters and presents each received byte on a one-entry valid/ready holding register to the USART register block. It is the stage that consumes the bit stream driven onto the board-level RX pin and feeds the peripheral bus side.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame, LSB first.
- `DIV_W`, 16, width of the bit-period divisor.

Ports:
- `io_clk`  in  1  system clock; the only clock.
- `io_rst`  in  1  reset, synchronous and active-high.
- `io_rx`  in  1  asynchronous serial input; idle high.
- `io_clkdiv`  in  DIV_W  clocks per bit; values below 4 are treated as 4.
- `io_parity_odd`  in  1  parity sense, 1 = odd; present only with `UART_RX_PARITY_EN`.
- `io_rx_data`  out  DATA_W  received byte.
- `io_rx_valid`  out  1  holding register full.
- `io_rx_ready`  in  1  consumer accepts `io_rx_data` when high with `io_rx_valid`.
- `io_frame_err`  out  1  stop bit sampled low for the held byte.
- `io_parity_err`  out  1  parity mismatch for the held byte; constant 0 without the macro.
- `io_overrun`  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- `io_busy`  out  1  high in any state other than IDLE.

## Operation
- `io_rx` passes through a 2-FF synchronizer; both stages and the edge-detect register reset to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: a synchronized falling edge (prev 1, now 0) loads the bit counter with `clkdiv>>1` and moves to START. A line already low at reset release is not a start.
- Bit counter decrements each cycle; a sample is taken when it reaches 0.
- START: sample = 1 -> false start, return to IDLE. Sample = 0 -> reload `clkdiv-1`, enter DATA.
- DATA: each sample shifts into the shift register MSB side (LSB-first reception) and reloads `clkdiv-1`. After `DATA_W` samples, go to PARITY if compiled in, else STOP.
- PARITY: the sample is compared with XOR of the data bits (XNOR when `io_parity_odd`=1). Reload, then STOP.
- STOP: on the sample, the frame completes and the FSM returns directly to IDLE (mid-stop-bit), so back-to-back frames are received.
- On completion, if the holding register is empty, or is being drained in the same cycle (`valid & ready`), it loads data, frame_err = !stop_sample and parity_err. Otherwise the new byte is dropped, the held byte and its flags are kept unchanged, and `io_overrun` pulses.
- `io_frame_err` and `io_parity_err` are qualified by `io_rx_valid` and are cleared on accept.
- `io_clkdiv` is read only at counter reloads; a change mid-frame applies from the next bit.

## Timing
- Reset values: `io_rx_data`=0, `io_rx_valid`=0, `io_frame_err`=0, `io_parity_err`=0, `io_overrun`=0, `io_busy`=0. FSM=IDLE. Counters=0.
- Reset mid-frame abandons the frame and clears the holding register. No byte and no overrun results.
- Pin-to-detect latency is 3 cycles (2 sync stages + edge register).
- `io_rx_valid` rises the cycle after the stop-bit sample cycle. `io_overrun` is high in that same cycle.
- Accept: `io_rx_valid` drops the cycle after `valid & ready`. The earliest next byte is 1 frame later.
- `io_busy` rises the cycle after edge detection and falls the cycle after the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state and the `io_parity_odd` port exist. The frame is 1 start bit, DATA_W data bits, 1 parity bit and 1 stop bit.
- Not defined: no parity bit is expected. `io_parity_err` is tied to 0 and `io_parity_odd` is absent. The frame is 8N1.

## Test plan
- 27 MHz clock, `io_clkdiv`=4, 150 ns bits, send 0xAA, `io_rx_ready` held 0 -> `io_rx_valid`=1, `io_rx_data`=0xAA, both error flags 0. Assert ready -> valid drops next cycle.
- Drive `io_rx` low for 1 clock, then high -> `io_busy` pulses and returns to IDLE with no `io_rx_valid`.
- Send 0x55 with the stop bit driven 0 -> `io_rx_data`=0x55 and `io_frame_err`=1. The next frame 0x0F is received with `io_frame_err`=0.
- Send 0x11 then 0x22 back-to-back with ready=0 -> 0x11 is held, `io_overrun` pulses once at the end of 0x22, and `io_rx_data` remains 0x11.
- With the macro, odd parity, send 0x03 with parity bit 0 -> `io_parity_err`=1. Repeat with parity bit 1 -> `io_parity_err`=0.
- Assert `io_rst` during data bit 4 of 0xC3 -> all outputs return to reset values. A following 0x7E frame is received correctly.
